// File: rtl/seg7_status_ctrl.sv
// seg7_status_ctrl: board status display driver.
// A prescaler produces a periodic tick that advances an event counter, a walking
// LED and a blink phase. A host-written data register can be shown instead of the
// counter. The selected content is encoded onto active-low 7-segment digits and an
// LED bar, both registered so every display change lands one cycle after its cause.
module seg7_status_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int LED_W      = 18,
  parameter int TICK_DIV   = 12500000,
  parameter int PRESCALE_W = 24
) (
  input  logic                    iCLK,
  input  logic                    iRST_n,
  input  logic [1:0]              iMODE,
  input  logic                    iPAUSE,
  input  logic                    iWR_EN,
  input  logic [4*NUM_DIGITS-1:0] iWR_DATA,
  input  logic [NUM_DIGITS-1:0]   iBLANK_MASK,
  output logic [7*NUM_DIGITS-1:0] oHEX,
  output logic [LED_W-1:0]        oLED,
  output logic                    oTICK,
  output logic [4*NUM_DIGITS-1:0] oCOUNT
);

  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICK_DIV - 1);
  localparam logic [6:0] SEG_DARK = 7'h7F;
  localparam logic [6:0] SEG_ALL_ON = 7'h00;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_DATA  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_LAMP  = 2'd3
  } mode_t;

  mode_t                   mode;
  logic [PRESCALE_W-1:0]   prescale_reg;
  logic [PRESCALE_W-1:0]   prescale_next;
  logic                    tick;
  logic                    tick_reg;
  logic                    advance;
  logic [DATA_W-1:0]       count_reg;
  logic [DATA_W-1:0]       data_reg;
  logic [LED_W-1:0]        led_reg;
  logic [LED_W-1:0]        led_rot;
  logic [LED_W-1:0]        led_data;
  logic [LED_W-1:0]        led_next;
  logic [LED_W-1:0]        led_out_reg;
  logic                    phase_reg;
  logic [7*NUM_DIGITS-1:0] hex_next;
  logic [7*NUM_DIGITS-1:0] hex_reg;

  assign mode          = mode_t'(iMODE);
  assign tick          = (prescale_reg == TICK_LAST);
  assign prescale_next = tick ? '0 : prescale_reg + PRESCALE_W'(1);
  // Counter and LED walk only move on a tick while not paused.
  assign advance       = tick && !iPAUSE;

  // Standard hexadecimal glyphs, active-low, bit0 = segment a.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Rotate left with wrap; a single-bit bar simply keeps its one lit bit.
  generate
    if (LED_W > 1) begin : g_rot_wide
      assign led_rot = {led_reg[LED_W-2:0], led_reg[LED_W-1]};
    end else begin : g_rot_single
      assign led_rot = led_reg;
    end
  endgenerate

  // The data register drives the bar in DATA mode, truncated or zero-extended to fit.
  generate
    if (LED_W <= DATA_W) begin : g_led_trunc
      assign led_data = data_reg[LED_W-1:0];
    end else begin : g_led_ext
      assign led_data = {{(LED_W - DATA_W){1'b0}}, data_reg};
    end
  endgenerate

  // Per-digit content select: lamp test overrides blanking, blanking overrides content.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] count_nib;
      logic [3:0] data_nib;
      assign count_nib = count_reg[4*gi +: 4];
      assign data_nib  = data_reg[4*gi +: 4];
      assign hex_next[7*gi +: 7] =
          (mode == MODE_LAMP)  ? SEG_ALL_ON :
          iBLANK_MASK[gi]      ? SEG_DARK :
          (mode == MODE_COUNT) ? seg_encode(count_nib) :
          (mode == MODE_DATA)  ? seg_encode(data_nib) :
          phase_reg            ? seg_encode(data_nib) : SEG_DARK;
    end
  endgenerate

  // LED bar source by mode.
  always_comb begin
    led_next = led_reg;
    case (mode)
      MODE_DATA: led_next = led_data;
      MODE_LAMP: led_next = '1;
      default:   led_next = led_reg;
    endcase
  end

  // Free-running prescaler and its registered tick pulse.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      prescale_reg <= '0;
      tick_reg     <= 1'b0;
    end else begin
      prescale_reg <= prescale_next;
      tick_reg     <= tick;
    end
  end

  // Event counter, LED walk and blink phase; blink ignores pause so it never freezes.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      count_reg <= '0;
      led_reg   <= LED_W'(1);
      phase_reg <= 1'b0;
    end else begin
      if (advance) begin
        count_reg <= count_reg + DATA_W'(1);
        led_reg   <= led_rot;
      end
      if (tick) begin
        phase_reg <= ~phase_reg;
      end
    end
  end

  // Host data register, independent of the tick so both can happen in one cycle.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      data_reg <= '0;
    end else if (iWR_EN) begin
      data_reg <= iWR_DATA;
    end
  end

  // Registered pin drivers: display dark and LEDs off while in reset.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hex_reg     <= '1;
      led_out_reg <= '0;
    end else begin
      hex_reg     <= hex_next;
      led_out_reg <= led_next;
    end
  end

  assign oHEX   = hex_reg;
  assign oLED   = led_out_reg;
  assign oTICK  = tick_reg;
  assign oCOUNT = count_reg;

endmodule

// File: tb/tb_seg7_status_ctrl.sv
// Testbench for seg7_status_ctrl: stimulus pushes expected outputs into a queue,
// a monitor pops one entry per clock and compares against the DUT outputs.
module tb_seg7_status_ctrl;

  localparam int ND = 4;
  localparam int LW = 6;
  localparam int TD = 4;
  localparam int M_COUNT = 0, M_DATA = 1, M_BLINK = 2, M_LAMP = 3;
  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
      7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic             iCLK;
  logic             iRST_n;
  logic [1:0]       iMODE;
  logic             iPAUSE;
  logic             iWR_EN;
  logic [4*ND-1:0]  iWR_DATA;
  logic [ND-1:0]    iBLANK_MASK;
  logic [7*ND-1:0]  oHEX;
  logic [LW-1:0]    oLED;
  logic             oTICK;
  logic [4*ND-1:0]  oCOUNT;

  seg7_status_ctrl #(
    .NUM_DIGITS(ND), .LED_W(LW), .TICK_DIV(TD), .PRESCALE_W(3)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iMODE(iMODE), .iPAUSE(iPAUSE),
    .iWR_EN(iWR_EN), .iWR_DATA(iWR_DATA), .iBLANK_MASK(iBLANK_MASK),
    .oHEX(oHEX), .oLED(oLED), .oTICK(oTICK), .oCOUNT(oCOUNT)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [7*ND-1:0] hex;
    logic [LW-1:0]   led;
    logic [4*ND-1:0] cnt;
    logic            tick;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference model state: cycles into the tick period, event count, host data,
  // blink phase and index of the lit LED.
  int m_pre, m_cnt, m_data, m_pos, m_phase;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_cnt = 0; m_data = 0; m_pos = 0; m_phase = 0;
  endtask

  function automatic logic [7*ND-1:0] ref_hex(input int mode, input int blank);
    logic [7*ND-1:0] h;
    int src;
    h = '0;
    src = (mode == M_COUNT) ? m_cnt : m_data;
    for (int i = 0; i < ND; i++) begin
      logic [6:0] d;
      if (mode == M_LAMP) d = 7'h00;
      else if (((blank >> i) & 1) != 0) d = 7'h7F;
      else if (mode == M_BLINK && m_phase == 0) d = 7'h7F;
      else d = SEG_TAB[(src >> (4 * i)) & 15];
      h[7*i +: 7] = d;
    end
    return h;
  endfunction

  // Drive one cycle of inputs (called at a falling edge), predict the outputs that
  // follow the next rising edge, advance the model, then move to the next falling edge.
  task automatic step(input int mode, input int pause, input int wr, input int wdata,
                      input int blank);
    exp_t e;
    int   tick;
    iMODE = 2'(mode); iPAUSE = 1'(pause); iWR_EN = 1'(wr);
    iWR_DATA = 16'(wdata); iBLANK_MASK = 4'(blank);
    tick = (m_pre == TD - 1) ? 1 : 0;
    e.hex = ref_hex(mode, blank);
    if (mode == M_LAMP) e.led = '1;
    else if (mode == M_DATA) e.led = LW'(m_data % (1 << LW));
    else e.led = LW'(1 << m_pos);
    m_pre = (m_pre + 1) % TD;
    if (tick == 1 && pause == 0) begin
      m_cnt = (m_cnt + 1) % 65536;
      m_pos = (m_pos + 1) % LW;
    end
    if (tick == 1) m_phase = 1 - m_phase;
    if (wr != 0) m_data = wdata;
    e.cnt = 16'(m_cnt);
    e.tick = 1'(tick);
    sb_q.push_back(e);
    @(negedge iCLK);
  endtask

  // Monitor: every output is valid each cycle once an expectation is pending.
  always @(posedge iCLK) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("sb_hex", 32'(oHEX), 32'(e.hex));
      chk("sb_led", 32'(oLED), 32'(e.led));
      chk("sb_count", 32'(oCOUNT), 32'(e.cnt));
      chk("sb_tick", 32'(oTICK), 32'(e.tick));
    end
  end

  task automatic check_reset_now(input string tag);
    #1;
    chk({tag, "_hex"}, 32'(oHEX), 32'({(7*ND){1'b1}}));
    chk({tag, "_led"}, 32'(oLED), 32'd0);
    chk({tag, "_count"}, 32'(oCOUNT), 32'd0);
    chk({tag, "_tick"}, 32'(oTICK), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_n = 1'b1;
    model_reset();
  endtask

  task automatic random_run(input int n);
    int mode, pause, blank;
    mode = M_COUNT; pause = 0; blank = 0;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 15) == 0) mode = int'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) pause = int'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) blank = int'($urandom_range(0, 15));
      step(mode, pause, ($urandom_range(0, 7) == 0) ? 1 : 0,
           int'($urandom_range(0, 65535)), blank);
    end
  endtask

  initial begin
    int guard;
    int saved_cnt;
    iRST_n = 1'b1; iMODE = '0; iPAUSE = 1'b0; iWR_EN = 1'b0;
    iWR_DATA = '0; iBLANK_MASK = '0;
    #3 iRST_n = 1'b0;
    check_reset_now("reset_initial");
    release_reset();

    // COUNT: 20 ticks take 80 edges; one more edge puts 0x14 on the digits.
    for (int k = 0; k < 81; k++) step(M_COUNT, 0, 0, 0, 0);
    chk("count_20_ticks", 32'(oCOUNT), 32'h0014);
    chk("count_digit0_4", 32'(oHEX[6:0]), 32'h19);
    chk("count_digit1_1", 32'(oHEX[13:7]), 32'h79);

    // Wrap: preload the counter to 0xFFFF away from a tick edge, then tick once more.
    if (m_pre == TD - 1) step(M_COUNT, 0, 0, 0, 0);
    force dut.count_reg = 16'hFFFF;
    release dut.count_reg;
    m_cnt = 65535;
    guard = 0;
    while (m_cnt != 0 && guard < 20) begin
      step(M_COUNT, 0, 0, 0, 0);
      guard++;
    end
    step(M_COUNT, 0, 0, 0, 0);
    chk("wrap_count", 32'(oCOUNT), 32'h0000);
    chk("wrap_digits", 32'(oHEX), 32'({ND{7'h40}}));

    // DATA: host write lands on the same edge as a tick.
    guard = 0;
    while (m_pre != TD - 1 && guard < 8) begin
      step(M_DATA, 0, 0, 0, 0);
      guard++;
    end
    saved_cnt = m_cnt;
    step(M_DATA, 0, 1, 16'hBEEF, 0);
    chk("tick_wr_count", 32'(oCOUNT), 32'((saved_cnt + 1) % 65536));
    step(M_DATA, 0, 0, 0, 0);
    chk("data_beef", 32'(oHEX), {4'h0, 7'h03, 7'h06, 7'h06, 7'h0E});
    step(M_DATA, 0, 0, 0, 1);
    chk("data_blank0", 32'(oHEX[6:0]), 32'h7F);

    // BLINK while paused: digits alternate, counter holds.
    step(M_BLINK, 1, 1, 16'h1234, 0);
    saved_cnt = m_cnt;
    for (int k = 0; k < 24; k++) step(M_BLINK, 1, 0, 0, 0);
    chk("blink_pause_count", 32'(oCOUNT), 32'(saved_cnt));

    // LAMP overrides blanking; returning to COUNT shows the unchanged counter.
    step(M_LAMP, 1, 0, 0, 15);
    chk("lamp_hex", 32'(oHEX), 32'd0);
    chk("lamp_led", 32'(oLED), 32'h3F);
    step(M_COUNT, 1, 0, 0, 0);
    chk("lamp_back_count", 32'(oCOUNT), 32'(saved_cnt));

    random_run(3000);

    // Reset asserted mid-run takes effect without a clock edge.
    iRST_n = 1'b0;
    check_reset_now("reset_midrun");
    release_reset();
    random_run(500);

    @(posedge iCLK);
    #2;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
